// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
//   NOTLOAD      : e_info_load code meaning "the E instruction is not a load"
//   state_e      : controller FSM states (RUN, LDUSE, MEMWAIT, REDIRECT)
//   FWD_*        : operand select codes driven on fwd1/fwd2
package pipeline_ctrl_pkg;

    localparam logic [2:0] NOTLOAD = 3'b000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LDUSE    = 2'd1,
        ST_MEMWAIT  = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    localparam logic [1:0] FWD_RF = 2'd0;  // register file value
    localparam logic [1:0] FWD_M  = 2'd1;  // result leaving M
    localparam logic [1:0] FWD_W  = 2'd2;  // result leaving W

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Forwarding select for one source operand of the instruction in D.
//   rs_i            : source register number
//   e_dst_i/e_wr_i  : instruction now in E (will be in M when rs_i's owner is in E)
//   m_dst_i/m_wr_i  : M shadow (will be in W when rs_i's owner is in E)
//   sel_o           : FWD_M, FWD_W or FWD_RF; the nearer producer wins, x0 never forwards
module pipeline_ctrl_fwd_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] rs_i,
    input  logic [W-1:0] e_dst_i,
    input  logic         e_wr_i,
    input  logic [W-1:0] m_dst_i,
    input  logic         m_wr_i,
    output logic [1:0]   sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (rs_i != '0) begin
            if (e_wr_i && (e_dst_i == rs_i)) begin
                sel_o = FWD_M;
            end else if (m_wr_i && (m_dst_i == rs_i)) begin
                sel_o = FWD_W;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32I pipeline (F, D, E, M, W).
// Inputs : clk, rst_n (async, active low), D-stage source regs and use flags,
//          E-stage destination/write/load info, branch_taken from E,
//          data-memory handshake from M (mem_req, mem_ready).
// Outputs: hold_pc, hold_ir, hold_ex, bubble (decoder flush), registered
//          forwarding selects fwd1/fwd2, busy_state (registered FSM state).
// Event priority each cycle: memory wait, then taken branch, then load-use.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int BRANCH_PENALTY = 2,
    parameter int XLEN_REG       = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [XLEN_REG-1:0] d_rs1,
    input  logic [XLEN_REG-1:0] d_rs2,
    input  logic                d_use_rs1,
    input  logic                d_use_rs2,
    input  logic [XLEN_REG-1:0] e_dst,
    input  logic                e_write_reg,
    input  logic [2:0]          e_info_load,
    input  logic                branch_taken,
    input  logic                mem_req,
    input  logic                mem_ready,
    output logic                hold_pc,
    output logic                hold_ir,
    output logic                hold_ex,
    output logic                bubble,
    output logic [1:0]          fwd1,
    output logic [1:0]          fwd2,
    output logic [1:0]          busy_state
);

    // Counter holds the number of REDIRECT cycles still to run.
    localparam logic [1:0] CNT_INIT = 2'(BRANCH_PENALTY - 1);

    state_e              state_q, state_d;
    state_e              saved_q, saved_d;   // state to resume after a memory wait
    state_e              eff_state;
    logic [1:0]          cnt_q, cnt_d;
    logic [XLEN_REG-1:0] m_dst_q, m_dst_d, w_dst_q, w_dst_d;
    logic                m_wr_q, m_wr_d, w_wr_q, w_wr_d;
    logic [1:0]          fwd1_q, fwd2_q, fwd1_d, fwd2_d;

    logic memwait, br_take, ld_hazard, ld_use;
    logic hold_pc_c, hold_ir_c, hold_ex_c, bubble_c;

    // While waiting on memory, everything behaves as the state we came from.
    assign eff_state = (state_q == ST_MEMWAIT) ? saved_q : state_q;

    assign memwait   = mem_req && !mem_ready;
    // A branch inside REDIRECT belongs to a bubble and is ignored.
    assign br_take   = branch_taken && !memwait && (eff_state != ST_REDIRECT);
    assign ld_hazard = (e_info_load != NOTLOAD) && e_write_reg && (e_dst != '0) &&
                       ((d_use_rs1 && (d_rs1 == e_dst)) || (d_use_rs2 && (d_rs2 == e_dst)));
    assign ld_use    = ld_hazard && !memwait && !br_take && (eff_state == ST_RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        if (memwait) begin
            state_d = ST_MEMWAIT;
            if (state_q != ST_MEMWAIT) begin
                saved_d = state_q;
            end
        end else if (br_take) begin
            cnt_d   = CNT_INIT;
            state_d = (CNT_INIT == 2'd0) ? ST_RUN : ST_REDIRECT;
        end else begin
            case (eff_state)
                ST_REDIRECT: begin
                    cnt_d   = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
                    state_d = (cnt_q <= 2'd1) ? ST_RUN : ST_REDIRECT;
                end
                ST_RUN:  state_d = ld_use ? ST_LDUSE : ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Output logic
    always_comb begin
        hold_pc_c = 1'b0;
        hold_ir_c = 1'b0;
        hold_ex_c = 1'b0;
        bubble_c  = 1'b0;
        if (memwait) begin
            hold_pc_c = 1'b1;
            hold_ir_c = 1'b1;
            hold_ex_c = 1'b1;
        end else if (br_take || (eff_state == ST_REDIRECT)) begin
            bubble_c  = 1'b1;
        end else if (ld_use) begin
            hold_pc_c = 1'b1;
            hold_ir_c = 1'b1;
            bubble_c  = 1'b1;
        end
    end

    // Reset forces a flush into E and releases every hold.
    assign hold_pc    = hold_pc_c && rst_n;
    assign hold_ir    = hold_ir_c && rst_n;
    assign hold_ex    = hold_ex_c && rst_n;
    assign bubble     = bubble_c || !rst_n;
    assign busy_state = state_q;

    // Shadow pipeline of destinations; a bubble cycle hands a NOP to M.
    always_comb begin
        m_dst_d = m_dst_q;
        m_wr_d  = m_wr_q;
        w_dst_d = w_dst_q;
        w_wr_d  = w_wr_q;
        if (!hold_ex_c) begin
            m_dst_d = bubble_c ? '0 : e_dst;
            m_wr_d  = e_write_reg && !bubble_c;
            w_dst_d = m_dst_q;
            w_wr_d  = m_wr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dst_q <= '0;
            m_wr_q  <= 1'b0;
            w_dst_q <= '0;
            w_wr_q  <= 1'b0;
        end else begin
            m_dst_q <= m_dst_d;
            m_wr_q  <= m_wr_d;
            w_dst_q <= w_dst_d;
            w_wr_q  <= w_wr_d;
        end
    end

    // W shadow is kept for debug probing only; nothing downstream reads it.
    logic unused_w_shadow;
    assign unused_w_shadow = ^{w_dst_q, w_wr_q};

    pipeline_ctrl_fwd_unit #(.W(XLEN_REG)) u_fwd1 (
        .rs_i    (d_rs1),
        .e_dst_i (e_dst),
        .e_wr_i  (e_write_reg),
        .m_dst_i (m_dst_q),
        .m_wr_i  (m_wr_q),
        .sel_o   (fwd1_d)
    );

    pipeline_ctrl_fwd_unit #(.W(XLEN_REG)) u_fwd2 (
        .rs_i    (d_rs2),
        .e_dst_i (e_dst),
        .e_wr_i  (e_write_reg),
        .m_dst_i (m_dst_q),
        .m_wr_i  (m_wr_q),
        .sel_o   (fwd2_d)
    );

    // Selects travel with the D instruction into E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd1_q <= FWD_RF;
            fwd2_q <= FWD_RF;
        end else if (!hold_ir_c) begin
            fwd1_q <= fwd1_d;
            fwd2_q <= fwd2_d;
        end
    end

    assign fwd1 = fwd1_q;
    assign fwd2 = fwd2_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] d_rs1, d_rs2, e_dst;
    logic       d_use_rs1, d_use_rs2, e_write_reg;
    logic [2:0] e_info_load;
    logic       branch_taken, mem_req, mem_ready;
    logic       hold_pc, hold_ir, hold_ex, bubble;
    logic [1:0] fwd1, fwd2, busy_state;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LW   = 3'b010;

    pipeline_ctrl #(.BRANCH_PENALTY(2), .XLEN_REG(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_rs1        (d_rs1),
        .d_rs2        (d_rs2),
        .d_use_rs1    (d_use_rs1),
        .d_use_rs2    (d_use_rs2),
        .e_dst        (e_dst),
        .e_write_reg  (e_write_reg),
        .e_info_load  (e_info_load),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .hold_pc      (hold_pc),
        .hold_ir      (hold_ir),
        .hold_ex      (hold_ex),
        .bubble       (bubble),
        .fwd1         (fwd1),
        .fwd2         (fwd2),
        .busy_state   (busy_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        d_rs1 = 5'd0; d_rs2 = 5'd0; d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
        e_dst = 5'd0; e_write_reg = 1'b0; e_info_load = LD_NONE;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // hold_pc, hold_ir, hold_ex, bubble packed MSB first
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, hold_pc, hold_ir, hold_ex, bubble}, {28'd0, exp});
    endtask

    task automatic set_loaduse();
        e_dst = 5'd5; e_write_reg = 1'b1; e_info_load = LD_LW;   // lw x5
        d_rs1 = 5'd5; d_use_rs1 = 1'b1;                           // add x6,x5,x7
        d_rs2 = 5'd7; d_use_rs2 = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        settle();

        // ---------------- reset ----------------
        check_ctl("rst_ctl", 4'b0001);
        check("rst_busy", busy_state, 2'd0);
        check("rst_fwd", {fwd1, fwd2}, 4'd0);
        tick();
        rst_n = 1'b1;
        settle();
        check_ctl("rel_ctl", 4'b0000);

        // reset while in REDIRECT with one cycle left
        branch_taken = 1'b1;
        settle();
        check_ctl("rr_br_ctl", 4'b0001);
        tick();
        branch_taken = 1'b0;
        settle();
        check("rr_busy_redir", busy_state, 2'd3);
        rst_n = 1'b0;
        settle();
        check("rr_busy_async", busy_state, 2'd0);
        check_ctl("rr_low_ctl", 4'b0001);
        tick();
        rst_n = 1'b1;
        settle();
        check_ctl("rr_rel_ctl", 4'b0000);
        tick();
        check_ctl("rr_no_residual", 4'b0000);
        check("rr_busy_run", busy_state, 2'd0);

        // ---------------- taken branch ----------------
        branch_taken = 1'b1;
        settle();
        check_ctl("br_c0_ctl", 4'b0001);
        check("br_c0_busy", busy_state, 2'd0);
        tick();
        branch_taken = 1'b0;
        settle();
        check_ctl("br_c1_ctl", 4'b0001);
        check("br_c1_busy", busy_state, 2'd3);
        tick();
        check_ctl("br_c2_ctl", 4'b0000);
        check("br_c2_busy", busy_state, 2'd0);

        // ---------------- load-use ----------------
        set_loaduse();
        settle();
        check_ctl("lu_stall_ctl", 4'b1101);
        tick();
        settle();
        check("lu_busy_lduse", busy_state, 2'd1);
        check_ctl("lu_lduse_ctl", 4'b0000);
        tick();
        idle_inputs();
        settle();
        check("lu_busy_run", busy_state, 2'd0);
        check("lu_fwd1", fwd1, 2'd1);
        check("lu_fwd2", fwd2, 2'd0);
        tick();
        tick();
        tick();

        // ---------------- memory wait inside REDIRECT ----------------
        e_dst = 5'd9; e_write_reg = 1'b1;
        tick();
        e_dst = 5'd10;
        tick();
        e_dst = 5'd0; e_write_reg = 1'b0;
        branch_taken = 1'b1;              // shadows become m=0, w=10
        tick();
        branch_taken = 1'b0;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_ctl($sformatf("mw_wait%0d_ctl", i), 4'b1110);
            tick();
            check("mw_busy", busy_state, 2'd2);
        end
        check("mw_m_dst", dut.m_dst_q, 5'd0);
        check("mw_w_dst", dut.w_dst_q, 5'd10);
        mem_ready = 1'b1;
        settle();
        check_ctl("mw_resume_ctl", 4'b0001);
        tick();
        idle_inputs();
        settle();
        check_ctl("mw_done_ctl", 4'b0000);
        check("mw_done_busy", busy_state, 2'd0);

        // ---------------- branch + load-use ----------------
        set_loaduse();
        branch_taken = 1'b1;
        settle();
        check_ctl("bl_c0_ctl", 4'b0001);
        tick();
        idle_inputs();
        settle();
        check("bl_busy", busy_state, 2'd3);
        check_ctl("bl_c1_ctl", 4'b0001);
        tick();
        check("bl_busy_run", busy_state, 2'd0);
        check_ctl("bl_c2_ctl", 4'b0000);

        // ---------------- branch + memwait ----------------
        branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        settle();
        check_ctl("bm_wait_ctl", 4'b1110);
        tick();
        check("bm_busy_wait", busy_state, 2'd2);
        mem_ready = 1'b1;
        settle();
        check_ctl("bm_ready_ctl", 4'b0001);
        tick();
        idle_inputs();
        settle();
        check("bm_busy_redir", busy_state, 2'd3);
        check_ctl("bm_redir_ctl", 4'b0001);
        tick();
        check("bm_busy_run", busy_state, 2'd0);

        // ---------------- forwarding priority and x0 ----------------
        tick();
        e_dst = 5'd3; e_write_reg = 1'b1;
        tick();                            // M shadow now x3
        d_rs1 = 5'd3; d_rs2 = 5'd3; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1;
        tick();
        check("fw_both_fwd1", fwd1, 2'd1);
        check("fw_both_fwd2", fwd2, 2'd1);
        e_dst = 5'd4; d_rs2 = 5'd4;        // M shadow still x3
        tick();
        check("fw_monly_fwd1", fwd1, 2'd2);
        check("fw_e4_fwd2", fwd2, 2'd1);
        e_dst = 5'd0; e_info_load = LD_LW; d_rs1 = 5'd0; d_rs2 = 5'd0;
        settle();
        check_ctl("fw_x0_nostall", 4'b0000);
        tick();
        check("fw_x0_fwd", {fwd1, fwd2}, 4'd0);
        idle_inputs();
        d_rs1 = 5'd0; d_use_rs1 = 1'b1;    // M shadow is a write to x0
        tick();
        check("fw_x0_mshadow", fwd1, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
